// File: rtl/upbus_pkg.sv
// upbus_pkg -- shared definitions for the CPU-bus hub.
//   upbus_state_e : transaction FSM states (IDLE, STRB, WAIT, ACK)
//   LOC_*         : register offsets (upa[3:0]) inside the local page
//   UPBUS_TODATA  : read data returned for a timed-out or unmapped access
package upbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STRB = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } upbus_state_e;

    localparam logic [3:0] LOC_INTMASK = 4'd0;
    localparam logic [3:0] LOC_TOSTAT  = 4'd1;
    localparam logic [3:0] LOC_RAWINT  = 4'd2;

    localparam logic [31:0] UPBUS_TODATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/upbus_strb.sv
// upbus_strb -- brings the asynchronous CPU chip select into the clk domain.
// Ports:
//   clk, rst_   : system clock, asynchronous active-low reset
//   ce_n_async  : raw eupce_ from the pins (active low)
//   ce_n_sync   : two-flop synchronised chip select (active low)
//   ce_fall     : one-cycle pulse when the synchronised select goes low
//   ce_rise     : one-cycle pulse when the synchronised select goes high
module upbus_strb (
    input  logic clk,
    input  logic rst_,
    input  logic ce_n_async,
    output logic ce_n_sync,
    output logic ce_fall,
    output logic ce_rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = ce_n_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset to the deselected level so reset release never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign ce_n_sync = sync_q;
    assign ce_fall   = prev_q & ~sync_q;
    assign ce_rise   = ~prev_q & sync_q;

endmodule

// File: rtl/upbus_hub.sv
// upbus_hub -- CPU-bus hub between the chip CPU pins and NCH slave channels.
// Synchronises eupce_, latches address/data, decodes the top SELW address bits
// into a one-hot channel enable (index 2**SELW-1 is the local register page),
// issues a one-cycle read/write strobe, waits for the selected channel's ready
// and holds eupack until the CPU deselects.
// Optional feature macro: UPBUS_TIMEOUT_EN adds the WAIT timeout counter, the
// tostat register (bit0 = timed out, bits SELW:1 = channel) and its interrupt term.
// Ports:
//   clk, rst_        : clock, asynchronous active-low reset
//   eupa/eupce_/euprnw/eupdi : CPU address, chip select, read-not-write, write data
//   eupdo, eupack, eupint    : CPU read data, acknowledge, interrupt (all registered)
//   upa, updi        : latched address / write data to slaves
//   uprs, upws       : one-cycle read / write strobes
//   upen             : one-hot channel enable held for the whole access
//   updo_ch, uprdy_ch, upint_ch : per-channel read data, ready, interrupt level
// Handshake: an access starts on the synchronised falling edge of eupce_; the
// selected slave answers with uprdy_ch[sel] for at least one cycle while upen is
// high; eupack stays high until eupce_ is seen high again.
module upbus_hub
    import upbus_pkg::*;
#(
    parameter int              NCH    = 8,
    parameter int              AW     = 24,
    parameter int              DW     = 32,
    parameter int              SELW   = 3,
    parameter int              TOW    = 10,
    parameter logic [TOW-1:0]  TOVAL  = TOW'(1000),
    parameter logic [DW-1:0]   TODATA = DW'(UPBUS_TODATA)
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [AW-1:0]     eupa,
    input  logic              eupce_,
    input  logic              euprnw,
    input  logic [DW-1:0]     eupdi,
    output logic [DW-1:0]     eupdo,
    output logic              eupack,
    output logic              eupint,
    output logic [AW-1:0]     upa,
    output logic [DW-1:0]     updi,
    output logic              uprs,
    output logic              upws,
    output logic [NCH-1:0]    upen,
    input  logic [NCH*DW-1:0] updo_ch,
    input  logic [NCH-1:0]    uprdy_ch,
    input  logic [NCH-1:0]    upint_ch
);

    localparam logic [SELW-1:0] LOCAL_SEL = '1;
    localparam logic [SELW:0]   NCH_W     = (SELW+1)'(NCH);

    logic ce_n_sync, ce_fall, ce_rise;

    upbus_strb u_strb (
        .clk        (clk),
        .rst_       (rst_),
        .ce_n_async (eupce_),
        .ce_n_sync  (ce_n_sync),
        .ce_fall    (ce_fall),
        .ce_rise    (ce_rise)
    );

    upbus_state_e    state_q, state_d;
    logic [AW-1:0]   upa_q, upa_d;
    logic [DW-1:0]   updi_q, updi_d;
    logic            rnw_q, rnw_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [NCH-1:0]  upen_q, upen_d;
    logic            uprs_q, uprs_d, upws_q, upws_d;
    logic [DW-1:0]   eupdo_q, eupdo_d;
    logic            eupack_q, eupack_d;
    logic            eupint_q, eupint_d;
    logic [NCH-1:0]  intmask_q, intmask_d;
`ifdef UPBUS_TIMEOUT_EN
    logic [TOW-1:0]  cnt_q, cnt_d;
    logic [SELW:0]   tostat_q, tostat_d;
`endif

    logic [SELW-1:0] sel_in;
    logic            mapped_in, mapped_q;
    logic            sel_rdy;
    logic [DW-1:0]   sel_data, local_rdata;

    assign sel_in    = eupa[AW-1 -: SELW];
    assign mapped_in = ({1'b0, sel_in} < NCH_W);
    assign mapped_q  = ({1'b0, sel_q} < NCH_W);

    // Ready/data of the selected channel only; other channels are ignored.
    always_comb begin
        sel_rdy  = 1'b0;
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if ({1'b0, sel_q} == (SELW+1)'(k)) begin
                sel_rdy  = uprdy_ch[k];
                sel_data = updo_ch[k*DW +: DW];
            end
        end
    end

    always_comb begin
        local_rdata = '0;
        case (upa_q[3:0])
            LOC_INTMASK: local_rdata = DW'(intmask_q);
`ifdef UPBUS_TIMEOUT_EN
            LOC_TOSTAT:  local_rdata = DW'(tostat_q);
`else
            LOC_TOSTAT:  local_rdata = '0;
`endif
            LOC_RAWINT:  local_rdata = DW'(upint_ch);
            default:     local_rdata = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        upa_d     = upa_q;
        updi_d    = updi_q;
        rnw_d     = rnw_q;
        sel_d     = sel_q;
        upen_d    = upen_q;
        uprs_d    = 1'b0;
        upws_d    = 1'b0;
        eupdo_d   = eupdo_q;
        intmask_d = intmask_q;
`ifdef UPBUS_TIMEOUT_EN
        cnt_d     = cnt_q;
        tostat_d  = tostat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ce_fall) begin
                    upa_d   = eupa;
                    updi_d  = eupdi;
                    rnw_d   = euprnw;
                    sel_d   = sel_in;
                    // Strobe and enable are registered so they are valid
                    // throughout the STRB cycle.
                    upen_d  = mapped_in ? (NCH'(1) << sel_in) : '0;
                    uprs_d  = mapped_in & euprnw;
                    upws_d  = mapped_in & ~euprnw;
                    state_d = ST_STRB;
                end
            end
            ST_STRB: begin
                if (sel_q == LOCAL_SEL) begin
                    if (rnw_q) begin
                        eupdo_d = local_rdata;
                    end else begin
                        if (upa_q[3:0] == LOC_INTMASK) intmask_d = updi_q[NCH-1:0];
`ifdef UPBUS_TIMEOUT_EN
                        if (upa_q[3:0] == LOC_TOSTAT) tostat_d = tostat_q & ~updi_q[SELW:0];
`endif
                    end
                    state_d = ST_ACK;
                end else if (!mapped_q) begin
                    // Unmapped: reads get the filler word, writes are dropped.
                    if (rnw_q) eupdo_d = TODATA;
                    state_d = ST_ACK;
                end else begin
`ifdef UPBUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Ready is tested first so it wins over a same-cycle timeout.
                if (sel_rdy) begin
                    if (rnw_q) eupdo_d = sel_data;
                    state_d = ST_ACK;
`ifdef UPBUS_TIMEOUT_EN
                end else if (cnt_q == TOVAL - TOW'(1)) begin
                    eupdo_d  = TODATA;
                    tostat_d = {sel_q, 1'b1};
                    state_d  = ST_ACK;
                end else begin
                    cnt_d = cnt_q + TOW'(1);
`endif
                end
            end
            ST_ACK: begin
                // Level covers a deselect that happened before ACK was reached.
                if (ce_rise || ce_n_sync) begin
                    upen_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        eupack_d = (state_d == ST_ACK);
`ifdef UPBUS_TIMEOUT_EN
        eupint_d = (|(upint_ch & intmask_q)) | tostat_q[0];
`else
        eupint_d = |(upint_ch & intmask_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= ST_IDLE;
            upa_q     <= '0;
            updi_q    <= '0;
            rnw_q     <= 1'b0;
            sel_q     <= '0;
            upen_q    <= '0;
            uprs_q    <= 1'b0;
            upws_q    <= 1'b0;
            eupdo_q   <= '0;
            eupack_q  <= 1'b0;
            eupint_q  <= 1'b0;
            intmask_q <= '0;
`ifdef UPBUS_TIMEOUT_EN
            cnt_q     <= '0;
            tostat_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            upa_q     <= upa_d;
            updi_q    <= updi_d;
            rnw_q     <= rnw_d;
            sel_q     <= sel_d;
            upen_q    <= upen_d;
            uprs_q    <= uprs_d;
            upws_q    <= upws_d;
            eupdo_q   <= eupdo_d;
            eupack_q  <= eupack_d;
            eupint_q  <= eupint_d;
            intmask_q <= intmask_d;
`ifdef UPBUS_TIMEOUT_EN
            cnt_q     <= cnt_d;
            tostat_q  <= tostat_d;
`endif
        end
    end

    assign eupdo  = eupdo_q;
    assign eupack = eupack_q;
    assign eupint = eupint_q;
    assign upa    = upa_q;
    assign updi   = updi_q;
    assign uprs   = uprs_q;
    assign upws   = upws_q;
    assign upen   = upen_q;

endmodule

// File: tb/tb_upbus_hub.sv
// tb_upbus_hub -- directed plus randomized bench for upbus_hub built with NCH=6
// so that index 6 is unmapped and index 7 is the local page.
module tb_upbus_hub;

    localparam int          NCH    = 6;
    localparam int          AW     = 24;
    localparam int          DW     = 32;
    localparam int          TOVAL  = 1000;
    localparam logic [31:0] TODATA = 32'hDEAD_BEEF;

    logic              clk, rst_;
    logic [AW-1:0]     eupa;
    logic              eupce_, euprnw;
    logic [DW-1:0]     eupdi, eupdo;
    logic              eupack, eupint;
    logic [AW-1:0]     upa;
    logic [DW-1:0]     updi;
    logic              uprs, upws;
    logic [NCH-1:0]    upen;
    logic [NCH*DW-1:0] updo_ch;
    logic [NCH-1:0]    uprdy_ch, upint_ch;

    upbus_hub #(.NCH(NCH)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .eupa     (eupa),
        .eupce_   (eupce_),
        .euprnw   (euprnw),
        .eupdi    (eupdi),
        .eupdo    (eupdo),
        .eupack   (eupack),
        .eupint   (eupint),
        .upa      (upa),
        .updi     (updi),
        .uprs     (uprs),
        .upws     (upws),
        .upen     (upen),
        .updo_ch  (updo_ch),
        .uprdy_ch (uprdy_ch),
        .upint_ch (upint_ch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0]  ch_data [NCH];
    logic [NCH-1:0] intmask_m, upint_m;
    logic [3:0]     tostat_m;
    logic [DW-1:0]  exp_q [$];

    // Slave responder / strobe monitor state
    int             slave_delay;
    bit             slave_dead;
    logic [NCH-1:0] noise_rdy;
    int             rs_cnt, ws_cnt;
    logic [AW-1:0]  strb_upa;
    logic [DW-1:0]  strb_updi;
    bit             pend;
    int             pend_cd, pend_ch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slaves answer slave_delay cycles after the strobe cycle on the enabled
    // channel; noise_rdy drives ready on other channels to prove it is ignored.
    initial begin
        logic [NCH-1:0] rdy_v;
        uprdy_ch = '0;
        pend = 0;
        pend_cd = 0;
        pend_ch = 0;
        forever begin
            @(negedge clk);
            rdy_v = noise_rdy;
            if (pend) begin
                if (pend_cd == 0) begin
                    rdy_v[pend_ch] = 1'b1;
                    pend = 0;
                end else begin
                    pend_cd--;
                end
            end
            uprdy_ch = rdy_v;
            if (uprs === 1'b1 || upws === 1'b1) begin
                rs_cnt += int'(uprs);
                ws_cnt += int'(upws);
                strb_upa  = upa;
                strb_updi = updi;
                for (int k = 0; k < NCH; k++) if (upen[k]) pend_ch = k;
                if (!slave_dead) begin
                    pend = 1;
                    pend_cd = slave_delay - 1;
                end
            end
        end
    end

    task automatic drive_slaves();
        for (int k = 0; k < NCH; k++) updo_ch[k*DW +: DW] = ch_data[k];
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [2:0] s;
        s = a[AW-1 -: 3];
        if (s == 3'd7) begin
            case (a[3:0])
                4'd0:    return 32'(intmask_m);
                4'd1:    return 32'(tostat_m);
                4'd2:    return 32'(upint_m);
                default: return 32'd0;
            endcase
        end
        if (int'(s) >= NCH) return TODATA;
        return ch_data[s];
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] w);
        if (a[AW-1 -: 3] == 3'd7) begin
            if (a[3:0] == 4'd0) intmask_m = w[NCH-1:0];
`ifdef UPBUS_TIMEOUT_EN
            if (a[3:0] == 4'd1) tostat_m = tostat_m & ~w[3:0];
`endif
        end
    endtask

    function automatic logic exp_int();
        return (|(upint_m & intmask_m)) | tostat_m[0];
    endfunction

    // One CPU access: returns read data, cycles from chip-select low to ack
    // (-1 if no ack within budget) and the enable seen while acked.
    task automatic cpu_access(input logic [AW-1:0] addr, input logic rnw, input logic [DW-1:0] wdata,
                              input int hold, output logic [DW-1:0] rdata, output int lat,
                              output logic [NCH-1:0] en_at_ack);
        bit got;
        @(negedge clk);
        eupa = addr;
        euprnw = rnw;
        eupdi = wdata;
        rs_cnt = 0;
        ws_cnt = 0;
        eupce_ = 1'b0;
        got = 0;
        lat = 0;
        for (int i = 0; i < TOVAL + 50 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (eupack === 1'b1) got = 1;
        end
        if (!got) lat = -1;
        rdata = eupdo;
        en_at_ack = upen;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ack_held", 32'(eupack), 32'd1);
        end
        eupce_ = 1'b1;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (eupack === 1'b0) got = 1;
        end
        check("ack_release", 32'(got), 32'd1);
        check("upen_release", 32'(upen), 32'd0);
    endtask

    task automatic run_txn(input string tag, input logic [AW-1:0] addr, input logic rnw,
                           input logic [DW-1:0] wdata, input int delay, input int hold,
                           input logic [NCH-1:0] noise);
        logic [2:0]     s;
        bit             mapped;
        logic [DW-1:0]  rdata, exp_d;
        int             lat, exp_lat;
        logic [NCH-1:0] en, exp_en;
        s = addr[AW-1 -: 3];
        mapped = (int'(s) < NCH);
        slave_delay = delay;
        slave_dead = 0;
        noise_rdy = noise;
        exp_en = '0;
        if (mapped) begin
            noise_rdy[s] = 1'b0;
            exp_en[s] = 1'b1;
        end
        if (rnw) exp_q.push_back(model_read(addr));
        exp_lat = mapped ? 4 + delay : 4;
        cpu_access(addr, rnw, wdata, hold, rdata, lat, en);
        noise_rdy = '0;
        check($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s_upen", tag), 32'(en), 32'(exp_en));
        check($sformatf("%s_rs_cnt", tag), 32'(rs_cnt), (mapped && rnw) ? 32'd1 : 32'd0);
        check($sformatf("%s_ws_cnt", tag), 32'(ws_cnt), (mapped && !rnw) ? 32'd1 : 32'd0);
        if (mapped) check($sformatf("%s_upa", tag), 32'(strb_upa), 32'(addr));
        if (mapped && !rnw) check($sformatf("%s_updi", tag), strb_updi, wdata);
        if (rnw) begin
            exp_d = exp_q.pop_front();
            check($sformatf("%s_rdata", tag), rdata, exp_d);
        end else begin
            model_write(addr, wdata);
        end
        @(negedge clk);
        check($sformatf("%s_eupint", tag), 32'(eupint), 32'(exp_int()));
    endtask

    logic [AW-1:0]  r_addr;
    logic [2:0]     r_sel;
    logic [DW-1:0]  r_data;
    int             r_lat, acks;
    logic [NCH-1:0] r_en;

    initial begin
        rst_ = 1'b0;
        eupce_ = 1'b1;
        eupa = '0;
        euprnw = 1'b1;
        eupdi = '0;
        upint_ch = '0;
        updo_ch = '0;
        noise_rdy = '0;
        slave_delay = 1;
        slave_dead = 0;
        rs_cnt = 0;
        ws_cnt = 0;
        intmask_m = '0;
        upint_m = '0;
        tostat_m = '0;
        for (int k = 0; k < NCH; k++) ch_data[k] = $urandom;
        drive_slaves();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_eupdo", eupdo, 32'd0);
        check("reset_upa", 32'(upa), 32'd0);
        check("reset_updi", updi, 32'd0);
        check("reset_ctl", 32'({upen, eupack, eupint, uprs, upws}), 32'd0);
        rst_ = 1'b1;
        repeat (3) @(negedge clk);

        // Read channel 2, slave ready 3 cycles after the strobe
        ch_data[2] = 32'h1234_5678;
        drive_slaves();
        run_txn("rd_ch2", {3'd2, 21'h000100}, 1'b1, 32'h0, 3, 2, '0);

        // Write channel 0
        run_txn("wr_ch0", {3'd0, 21'h000055}, 1'b0, 32'hA5A5_A5A5, 2, 1, '0);

`ifdef UPBUS_TIMEOUT_EN
        // Read channel 5 with a dead slave: forced ack with the filler word
        slave_dead = 1;
        noise_rdy = '0;
        cpu_access({3'd5, 21'h000010}, 1'b1, 32'h0, 0, r_data, r_lat, r_en);
        slave_dead = 0;
        check("to_latency", 32'(r_lat), 32'(4 + TOVAL));
        check("to_rdata", r_data, TODATA);
        check("to_upen", 32'(r_en), 32'h20);
        tostat_m = {3'd5, 1'b1};
        @(negedge clk);
        check("to_eupint", 32'(eupint), 32'd1);
        run_txn("to_stat_rd", {3'd7, 17'h0, 4'd1}, 1'b1, 32'h0, 1, 0, '0);
        check("to_stat_model", 32'(tostat_m), 32'h0B);
        run_txn("to_stat_clr", {3'd7, 17'h0, 4'd1}, 1'b0, 32'hF, 1, 0, '0);
        run_txn("to_stat_rd2", {3'd7, 17'h0, 4'd1}, 1'b1, 32'h0, 1, 0, '0);
`else
        run_txn("stat_wr", {3'd7, 17'h0, 4'd1}, 1'b0, 32'hF, 1, 0, '0);
        run_txn("stat_rd", {3'd7, 17'h0, 4'd1}, 1'b1, 32'h0, 1, 0, '0);
`endif

        // Interrupt mask
        run_txn("wr_mask", {3'd7, 17'h0, 4'd0}, 1'b0, 32'h10, 1, 0, '0);
        run_txn("rd_mask", {3'd7, 17'h0, 4'd0}, 1'b1, 32'h0, 1, 0, '0);
        @(negedge clk);
        upint_ch = 6'h10;
        upint_m = 6'h10;
        @(negedge clk);
        check("int_ch4", 32'(eupint), 32'd1);
        upint_ch = 6'h08;
        upint_m = 6'h08;
        @(negedge clk);
        check("int_ch3_masked", 32'(eupint), 32'd0);
        run_txn("rd_rawint", {3'd7, 17'h0, 4'd2}, 1'b1, 32'h0, 1, 0, '0);

        // Unmapped index 6 with ready asserted on every channel
        run_txn("rd_unmapped", {3'd6, 21'h000200}, 1'b1, 32'h0, 1, 1, '1);
        run_txn("wr_unmapped", {3'd6, 21'h000200}, 1'b0, 32'h1111_2222, 1, 0, '1);

        // Chip select released mid-access: one-cycle ack, data still captured
        ch_data[3] = $urandom;
        drive_slaves();
        slave_delay = 5;
        noise_rdy = '0;
        @(negedge clk);
        eupa = {3'd3, 21'h000004};
        euprnw = 1'b1;
        eupce_ = 1'b0;
        repeat (3) @(negedge clk);
        eupce_ = 1'b1;
        acks = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (eupack === 1'b1) acks++;
        end
        check("rise_ack_pulse", 32'(acks), 32'd1);
        check("rise_rdata", eupdo, ch_data[3]);
        check("rise_upen", 32'(upen), 32'd0);

        // Asynchronous reset while waiting on a dead slave
        slave_dead = 1;
        @(negedge clk);
        eupa = {3'd1, 21'h000008};
        euprnw = 1'b1;
        eupce_ = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_pre_upen", 32'(upen), 32'h02);
        #2 rst_ = 1'b0;
        #1;
        check("rst_async_eupdo", eupdo, 32'd0);
        check("rst_async_upa", 32'(upa), 32'd0);
        check("rst_async_updi", updi, 32'd0);
        check("rst_async_ctl", 32'({upen, eupack, eupint, uprs, upws}), 32'd0);
        eupce_ = 1'b1;
        slave_dead = 0;
        intmask_m = '0;
        tostat_m = '0;
        @(negedge clk);
        rst_ = 1'b1;
        repeat (4) @(negedge clk);
        run_txn("post_rst_rd", {3'd1, 21'h000008}, 1'b1, 32'h0, 2, 0, '0);

        // Randomized accesses across mapped, unmapped and local indices
        for (int it = 0; it < 40; it++) begin
            r_sel = 3'($urandom_range(0, 7));
            upint_m = NCH'($urandom);
            upint_ch = upint_m;
            for (int k = 0; k < NCH; k++) ch_data[k] = $urandom;
            drive_slaves();
            r_addr = AW'($urandom);
            r_addr[AW-1 -: 3] = r_sel;
            if (r_sel == 3'd7) r_addr[3:0] = 4'($urandom_range(0, 4));
            run_txn($sformatf("rand%0d", it), r_addr, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(1, 6), $urandom_range(0, 2), NCH'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
